// File: rtl/crc7_frame_sequencer_if.sv
// Byte stream handshake between a producer and the CRC7 frame sequencer.
// The producer holds s_data/s_last stable until s_valid && s_ready.
interface crc7_frame_sequencer_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/crc7_frame_sequencer.sv
// Sequences an external serial CRC7 engine over one byte frame at a time and
// serialises the message bits followed by the 7 CRC bits onto tx_bit.
module crc7_frame_sequencer #(
  parameter int MAX_BYTES = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  crc7_frame_sequencer_if.slave  s,
  output logic                   crc_clear,
  output logic                   crc_enable,
  output logic                   crc_shift,
  output logic                   crc_in,
  input  logic                   crc_bit,
  output logic                   tx_bit,
  output logic                   tx_valid,
  output logic                   tx_is_crc,
  output logic                   busy,
  output logic                   done,
  output logic                   frame_err,
  output logic [6:0]             crc_value
);

  localparam int CW = $clog2(MAX_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_DATA,
    S_WAIT,
    S_CRC,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_sh;
  logic [2:0]      r_bit_cnt;
  logic [CW-1:0]   r_byte_cnt;
  logic            r_last_f;
  logic            r_forced;
  logic [6:0]      r_crc;

  logic            w_bit7;
  logic            w_ready;
  logic            w_xfer;
  logic [CW-1:0]   w_next_cnt;
  logic            w_at_cap;

  assign w_bit7 = (r_bit_cnt == 3'd7);

  // A new byte is taken in IDLE, in WAIT, or on the last bit of a
  // non-final byte so consecutive bytes stream without a gap.
  assign w_ready = (r_state == S_IDLE) || (r_state == S_WAIT) ||
                   ((r_state == S_DATA) && w_bit7 && !r_last_f);
  assign w_xfer  = s.s_valid && w_ready;

  assign w_next_cnt = (r_state == S_IDLE) ? CW'(1) : r_byte_cnt + CW'(1);
  assign w_at_cap   = (w_next_cnt == CW'(MAX_BYTES));

  assign s.s_ready = w_ready;
  assign busy      = (r_state != S_IDLE);
  assign crc_value = r_crc;

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next     = r_state;
    crc_clear  = 1'b0;
    crc_enable = 1'b0;
    crc_shift  = 1'b0;
    crc_in     = 1'b0;
    tx_bit     = 1'b0;
    tx_valid   = 1'b0;
    tx_is_crc  = 1'b0;
    done       = 1'b0;
    frame_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        crc_clear = 1'b1;
        w_next    = S_DATA;
      end
      S_DATA: begin
        crc_enable = 1'b1;
        crc_in     = r_sh[7];
        tx_bit     = r_sh[7];
        tx_valid   = 1'b1;
        if (w_bit7) begin
          if (r_last_f)     w_next = S_CRC;
          else if (!w_xfer) w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_xfer) w_next = S_DATA;
      end
      S_CRC: begin
        crc_shift = 1'b1;
        tx_bit    = crc_bit;
        tx_valid  = 1'b1;
        tx_is_crc = 1'b1;
        if (r_bit_cnt == 3'd6) w_next = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        frame_err = r_forced;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_sh       <= '0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_last_f   <= 1'b0;
      r_forced   <= 1'b0;
      r_crc      <= '0;
    end else begin
      r_state <= w_next;

      if (w_xfer) begin
        r_sh       <= s.s_data;
        r_byte_cnt <= w_next_cnt;
        r_last_f   <= s.s_last || w_at_cap;
        r_forced   <= !s.s_last && w_at_cap;
      end else if (r_state == S_DATA) begin
        r_sh <= {r_sh[6:0], 1'b0};
      end

      // bit_cnt wraps 7 -> 0 leaving DATA, so WAIT and CRC start from zero.
      case (r_state)
        S_CLEAR:      r_bit_cnt <= '0;
        S_DATA,
        S_CRC:        r_bit_cnt <= r_bit_cnt + 3'd1;
        default:      r_bit_cnt <= r_bit_cnt;
      endcase

      if (r_state == S_CRC) r_crc <= {r_crc[5:0], crc_bit};
    end
  end

endmodule
